// File: rtl/huc_timer_irq.sv
// ----------------------------------------------------------------------------
// huc_timer_irq
//
// Programmable down-counting timer plus a small interrupt controller that
// feeds the level-sensitive IRQ input of the 65C02 core. Both live in the
// hardware I/O page:
//   timer                : offsets 0x0C00-0x0FFF (addr[12:10] == 3'b011)
//   interrupt controller : offsets 0x1400-0x17FF (addr[12:10] == 3'b101)
// Only addr[1:0] selects a register; addr[9:2] are don't-care (mirrors).
//
//   timer +0 W : reload value          R : current counter (zero-extended)
//   timer +1 W : enable (di[0])        R : {7'b0, enable}
//   irqc  +2 RW: disable mask {timer, irq1, irq2}, 1 = disabled
//   irqc  +3 R : raw status {5'b0, tirq_pend, irq1, irq2}
//            W : any data clears tirq_pend (a same-cycle underflow wins)
//   other offsets read 0x00 and ignore writes.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   cs         CPU access targets the hardware I/O page this cycle
//   addr[12:0] offset within the I/O page
//   we         1 = write, 0 = read (qualified by cs)
//   di[7:0]    CPU write data
//   dout[7:0]  registered read data, valid the cycle after a read access
//   dout_valid dout holds read data for this block this cycle
//   irq1_in    external IRQ1 request, level, active high
//   irq2_in    external IRQ2 request, level, active high
//   irq        registered level IRQ to the CPU, active high
//   irq_src    highest-priority unmasked source: 2 timer, 1 IRQ1, 0 IRQ2/none
//
// Parameters:
//   PRESCALE   clk cycles per timer decrement (>= 2)
//   TIMER_BITS width of the counter and reload registers (<= 8)
//
// Build option:
//   IRQ_SYNC_EN  when defined, irq1_in/irq2_in pass through two-flop
//                synchronizers before status and interrupt logic, making the
//                external-line to irq latency 3 cycles instead of 1.
// ----------------------------------------------------------------------------
module huc_timer_irq #(
    parameter int PRESCALE   = 1024,
    parameter int TIMER_BITS = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic [12:0] addr,
    input  logic        we,
    input  logic [7:0]  di,
    output logic [7:0]  dout,
    output logic        dout_valid,
    input  logic        irq1_in,
    input  logic        irq2_in,
    output logic        irq,
    output logic [1:0]  irq_src
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int            PW        = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_TOP = PW'(PRESCALE - 1);

    localparam logic [2:0] PAGE_TIMER = 3'b011;
    localparam logic [2:0] PAGE_IRQC  = 3'b101;

    localparam logic [1:0] TMR_COUNT = 2'd0;
    localparam logic [1:0] TMR_CTRL  = 2'd1;
    localparam logic [1:0] IC_MASK   = 2'd2;
    localparam logic [1:0] IC_STATUS = 2'd3;

    localparam logic [1:0] SRC_TIMER = 2'd2;
    localparam logic [1:0] SRC_IRQ1  = 2'd1;
    localparam logic [1:0] SRC_NONE  = 2'd0;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [TIMER_BITS-1:0] reload;
    logic [TIMER_BITS-1:0] counter;
    logic                  enable;
    logic [PW-1:0]         presc;
    logic [2:0]            mask;
    logic                  tirq_pend;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic tmr_sel;
    logic ic_sel;
    logic tmr_wr;
    logic ic_wr;
    logic rd_access;

    assign tmr_sel   = cs && (addr[12:10] == PAGE_TIMER);
    assign ic_sel    = cs && (addr[12:10] == PAGE_IRQC);
    assign tmr_wr    = tmr_sel && we;
    assign ic_wr     = ic_sel && we;
    assign rd_access = (tmr_sel || ic_sel) && !we;

    // Mirror address bits and the data bits no register stores are
    // intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{addr[9:2], di};

    // ------------------------------------------------------------------
    // External request lines
    // ------------------------------------------------------------------
    logic [1:0] ext;    // {irq1, irq2} as seen by status and interrupt logic

`ifdef IRQ_SYNC_EN
    logic [1:0] ext_meta;
    logic [1:0] ext_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_meta <= 2'b00;
            ext_sync <= 2'b00;
        end else begin
            ext_meta <= {irq1_in, irq2_in};
            ext_sync <= ext_meta;
        end
    end

    assign ext = ext_sync;
`else
    assign ext = {irq1_in, irq2_in};
`endif

    // ------------------------------------------------------------------
    // Timer control
    // ------------------------------------------------------------------
    logic ctrl_wr;
    logic start;      // 0->1 enable write: load counter from reload
    logic stop_wr;    // writing 0 freezes counter and prescaler this cycle
    logic counting;
    logic presc_zero;
    logic underflow;

    assign ctrl_wr    = tmr_wr && (addr[1:0] == TMR_CTRL);
    assign start      = ctrl_wr && di[0] && !enable;
    assign stop_wr    = ctrl_wr && !di[0];
    assign counting   = enable && !stop_wr;
    assign presc_zero = (presc == '0);
    assign underflow  = counting && presc_zero && (counter == '0);

    // NOTE: every clocked process uses non-blocking (<=) assignments so all
    // registers sample the pre-edge values; e.g. a start loads the reload
    // value that was in effect before any write landing on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reload  <= '0;
            counter <= '0;
            enable  <= 1'b0;
            presc   <= '0;
        end else begin
            if (tmr_wr && (addr[1:0] == TMR_COUNT)) begin
                reload <= di[TIMER_BITS-1:0];
            end

            if (ctrl_wr) begin
                enable <= di[0];
            end

            if (start) begin
                counter <= reload;
                presc   <= PRESC_TOP;
            end else if (counting) begin
                if (presc_zero) begin
                    presc <= PRESC_TOP;
                    // Counter reaches 0 and stays there for one full
                    // prescale period before reloading, so the period is
                    // (reload + 1) * PRESCALE.
                    if (counter == '0) begin
                        counter <= reload;
                    end else begin
                        counter <= counter - TIMER_BITS'(1);
                    end
                end else begin
                    presc <= presc - PW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Interrupt controller registers
    // ------------------------------------------------------------------
    logic pend_clr;

    assign pend_clr = ic_wr && (addr[1:0] == IC_STATUS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask      <= 3'b000;
            tirq_pend <= 1'b0;
        end else begin
            if (ic_wr && (addr[1:0] == IC_MASK)) begin
                mask <= di[2:0];
            end

            // Set has priority so an underflow coinciding with an
            // acknowledge is never lost.
            if (underflow) begin
                tirq_pend <= 1'b1;
            end else if (pend_clr) begin
                tirq_pend <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Interrupt merge and priority encode
    // ------------------------------------------------------------------
    logic [2:0] act;
    logic [1:0] src_next;

    assign act = {tirq_pend, ext} & ~mask;

    // NOTE: combinational blocks assign a default to every output first,
    // so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        src_next = SRC_NONE;
        if (act[2]) begin
            src_next = SRC_TIMER;
        end else if (act[1]) begin
            src_next = SRC_IRQ1;
        end
    end

    // ------------------------------------------------------------------
    // Read mux (reads have no side effects)
    // ------------------------------------------------------------------
    logic [7:0] rd_data;

    always_comb begin
        rd_data = 8'h00;
        if (tmr_sel) begin
            case (addr[1:0])
                TMR_COUNT: rd_data = 8'(counter);
                TMR_CTRL:  rd_data = {7'b0, enable};
                default:   rd_data = 8'h00;
            endcase
        end else if (ic_sel) begin
            case (addr[1:0])
                IC_MASK:   rd_data = {5'b0, mask};
                IC_STATUS: rd_data = {5'b0, tirq_pend, ext};
                default:   rd_data = 8'h00;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout       <= 8'h00;
            dout_valid <= 1'b0;
            irq        <= 1'b0;
            irq_src    <= SRC_NONE;
        end else begin
            // dout keeps its last value between reads.
            if (rd_access) begin
                dout <= rd_data;
            end
            dout_valid <= rd_access;
            irq        <= |act;
            irq_src    <= src_next;
        end
    end

endmodule

// File: tb/tb_huc_timer_irq.sv
// ----------------------------------------------------------------------------
// tb_huc_timer_irq
//
// Self-checking bench for huc_timer_irq (PRESCALE = 4, TIMER_BITS = 7).
// A behavioural model, stepped once per clock from the documented register
// rules, predicts dout, dout_valid, irq and irq_src every cycle. Directed
// sequences and a vector table add hand-derived expectations for the timer
// period, masking, priority, freeze/restart, set-beats-clear and reset.
// ----------------------------------------------------------------------------
module tb_huc_timer_irq;

    localparam int PRESCALE   = 4;
    localparam int TIMER_BITS = 7;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs;
    logic [12:0] addr;
    logic        we;
    logic [7:0]  di;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        irq1_in;
    logic        irq2_in;
    logic        irq;
    logic [1:0]  irq_src;

    huc_timer_irq #(
        .PRESCALE   (PRESCALE),
        .TIMER_BITS (TIMER_BITS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cs         (cs),
        .addr       (addr),
        .we         (we),
        .di         (di),
        .dout       (dout),
        .dout_valid (dout_valid),
        .irq1_in    (irq1_in),
        .irq2_in    (irq2_in),
        .irq        (irq),
        .irq_src    (irq_src)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    int         m_reload, m_cnt, m_presc;
    bit         m_en, m_pend;
    bit [2:0]   m_mask;
    bit [7:0]   m_dout;
    bit         m_dv, m_irq;
    bit [1:0]   m_src;
    bit [1:0]   m_hist [2];   // external lines sampled one and two edges ago

    task automatic model_reset();
        m_reload = 0; m_cnt = 0; m_presc = 0;
        m_en = 0; m_pend = 0; m_mask = 3'b000;
        m_dout = 8'h00; m_dv = 0; m_irq = 0; m_src = 2'd0;
        m_hist[0] = 2'b00; m_hist[1] = 2'b00;
    endtask

    function automatic bit [7:0] model_read(input bit [12:0] a, input bit [1:0] ev);
        if (a[12:10] == 3'b011) begin
            if (a[1:0] == 2'd0) return 8'(m_cnt);
            if (a[1:0] == 2'd1) return {7'b0, m_en};
        end else if (a[12:10] == 3'b101) begin
            if (a[1:0] == 2'd2) return {5'b0, m_mask};
            if (a[1:0] == 2'd3) return {5'b0, m_pend, ev};
        end
        return 8'h00;
    endfunction

    task automatic model_step();
        bit [1:0] ev;
        bit [2:0] act;
        bit       tsel, isel, uf, run;
        int       n_reload, n_cnt, n_presc;
        bit       n_en;

`ifdef IRQ_SYNC_EN
        ev = m_hist[1];
`else
        ev = {irq1_in, irq2_in};
`endif
        tsel = cs && (addr[12:10] == 3'b011);
        isel = cs && (addr[12:10] == 3'b101);

        // read path (old state)
        if ((tsel || isel) && !we) begin
            m_dout = model_read(addr, ev);
            m_dv   = 1;
        end else begin
            m_dv   = 0;
        end

        // interrupt outputs (old state)
        act   = {m_pend, ev} & ~m_mask;
        m_irq = (act != 0);
        m_src = act[2] ? 2'd2 : (act[1] ? 2'd1 : 2'd0);

        // timer
        n_reload = m_reload; n_cnt = m_cnt; n_presc = m_presc; n_en = m_en;
        run = m_en; uf = 0;
        if (tsel && we && addr[1:0] == 2'd0) n_reload = int'(di) % (1 << TIMER_BITS);
        if (tsel && we && addr[1:0] == 2'd1) begin
            if (di[0] && !m_en) begin
                n_en = 1; n_cnt = m_reload; n_presc = PRESCALE - 1; run = 0;
            end else if (!di[0]) begin
                n_en = 0; run = 0;
            end
        end
        if (run) begin
            if (m_presc == 0) begin
                n_presc = PRESCALE - 1;
                if (m_cnt == 0) begin n_cnt = m_reload; uf = 1; end
                else n_cnt = m_cnt - 1;
            end else begin
                n_presc = m_presc - 1;
            end
        end

        // interrupt controller registers
        if (isel && we && addr[1:0] == 2'd2) m_mask = di[2:0];
        if (uf) m_pend = 1;
        else if (isel && we && addr[1:0] == 2'd3) m_pend = 0;

        m_reload = n_reload; m_cnt = n_cnt; m_presc = n_presc; m_en = n_en;
        m_hist[1] = m_hist[0];
        m_hist[0] = {irq1_in, irq2_in};
    endtask

    task automatic compare_model();
        check("model_dout",    dout,       m_dout);
        check("model_dvalid",  dout_valid, m_dv);
        check("model_irq",     irq,        m_irq);
        check("model_irq_src", irq_src,    m_src);
    endtask

    // ------------------------------------------------------------------
    // Bus helpers: inputs change 1 time unit after the edge, outputs are
    // sampled 1 time unit after the edge.
    // ------------------------------------------------------------------
    task automatic cycle();
        @(posedge clk);
        if (reset) model_reset();
        else       model_step();
        #1;
        compare_model();
    endtask

    task automatic set_idle();
        cs = 0; we = 0; addr = 13'h0000; di = 8'h00;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wr(input logic [12:0] a, input logic [7:0] d);
        cs = 1; we = 1; addr = a; di = d;
        cycle();
        set_idle();
    endtask

    task automatic rd(input logic [12:0] a, output logic [7:0] d);
        cs = 1; we = 0; addr = a; di = 8'h00;
        cycle();
        d = dout;
        set_idle();
    endtask

    // Waits (bounded) for irq to go high; returns cycles waited, 0 on timeout.
    task automatic wait_irq(input int limit, output int waited);
        waited = 0;
        for (int i = 1; i <= limit; i++) begin
            cycle();
            if (irq === 1'b1) begin
                waited = i;
                break;
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Vector table for mask / priority / level behaviour
    // ------------------------------------------------------------------
    typedef struct {
        logic        cs;
        logic        we;
        logic [12:0] addr;
        logic [7:0]  di;
        logic        i1;
        logic        i2;
        logic        e_irq;
        logic [1:0]  e_src;
        logic        e_dv;
        logic [7:0]  e_dout;
    } vec_t;

    vec_t tbl [13];

    initial begin
        logic [7:0] rv;
        logic [7:0] first;
        int         lat;
        bit         saw_irq;

        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rv;
        logic [7:0] first;
        int         lat;
        bit         saw_irq;

        // pending timer, mask 0, lines 11, dout holds 0x04 from the last read
        tbl[0]  = '{1'b1, 1'b1, 13'h1402, 8'h00, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 8'h04};
        tbl[1]  = '{1'b0, 1'b0, 13'h0000, 8'h00, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 8'h04};
        tbl[2]  = '{1'b1, 1'b1, 13'h1402, 8'h04, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 8'h04};
        tbl[3]  = '{1'b0, 1'b0, 13'h0000, 8'h00, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 8'h04};
        tbl[4]  = '{1'b1, 1'b1, 13'h1402, 8'h06, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 8'h04};
        tbl[5]  = '{1'b0, 1'b0, 13'h0000, 8'h00, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 8'h04};
        tbl[6]  = '{1'b1, 1'b1, 13'h1402, 8'h07, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 8'h04};
        tbl[7]  = '{1'b0, 1'b0, 13'h0000, 8'h00, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 8'h04};
        tbl[8]  = '{1'b1, 1'b0, 13'h1402, 8'h00, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 8'h07};
        tbl[9]  = '{1'b1, 1'b0, 13'h1403, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 8'h06};
        tbl[10] = '{1'b1, 1'b1, 13'h1402, 8'h05, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 8'h06};
        tbl[11] = '{1'b0, 1'b0, 13'h0000, 8'h00, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 8'h06};
        tbl[12] = '{1'b0, 1'b0, 13'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 8'h06};

        // ---------------- reset ----------------
        reset = 1; irq1_in = 0; irq2_in = 0;
        set_idle();
        model_reset();
        idle(2);
        check("rst_dout",    dout,       8'h00);
        check("rst_dvalid",  dout_valid, 1'b0);
        check("rst_irq",     irq,        1'b0);
        check("rst_irq_src", irq_src,    2'd0);
        reset = 0;
        rd(13'h0C00, rv); check("rst_counter", rv, 8'h00);
        rd(13'h0C01, rv); check("rst_enable",  rv, 8'h00);
        rd(13'h1402, rv); check("rst_mask",    rv, 8'h00);
        rd(13'h1403, rv); check("rst_status",  rv, 8'h00);

        // ---------------- timer period ----------------
        wr(13'h0C00, 8'h02);
        wr(13'h0C01, 8'h01);
        wait_irq(40, lat);
        check("tmr_irq_latency", lat, 13);
        check("tmr_irq_src", irq_src, 2'd2);
        rd(13'h1403, rv); check("tmr_status", rv, 8'h04);
        wr(13'h0C01, 8'h00);

        // ---------------- mask and acknowledge ----------------
        wr(13'h1402, 8'h04);
        idle(1);
        check("mask_irq_off", irq, 1'b0);
        rd(13'h1403, rv); check("mask_status_raw", rv, 8'h04);
        wr(13'h1402, 8'h00);
        idle(1);
        check("unmask_irq_on", irq, 1'b1);
        wr(13'h1403, 8'hFF);
        idle(1);
        check("ack_irq_off", irq, 1'b0);

        // ---------------- priority table ----------------
        wr(13'h0C01, 8'h01);
        wait_irq(40, lat);
        check("tbl_setup_irq", lat, 13);
        wr(13'h0C01, 8'h00);
`ifndef IRQ_SYNC_EN
        for (int i = 0; i < 13; i++) begin
            cs = tbl[i].cs; we = tbl[i].we; addr = tbl[i].addr; di = tbl[i].di;
            irq1_in = tbl[i].i1; irq2_in = tbl[i].i2;
            cycle();
            check($sformatf("tbl%0d_irq", i),     irq,        tbl[i].e_irq);
            check($sformatf("tbl%0d_irq_src", i), irq_src,    tbl[i].e_src);
            check($sformatf("tbl%0d_dvalid", i),  dout_valid, tbl[i].e_dv);
            check($sformatf("tbl%0d_dout", i),    dout,       tbl[i].e_dout);
        end
        set_idle();
`endif
        irq1_in = 0; irq2_in = 0;
        wr(13'h1402, 8'h00);
        idle(3);

        // ---------------- freeze and restart ----------------
        wr(13'h0C00, 8'h05);
        wr(13'h0C01, 8'h01);
        idle(6);
        wr(13'h0C01, 8'h00);
        rd(13'h0C00, first);
        check("freeze_value", first, 8'h04);
        for (int i = 0; i < 19; i++) begin
            rd(13'h0C00, rv);
            check("freeze_hold", rv, first);
        end
        wr(13'h0C01, 8'h01);
        rd(13'h0C00, rv);
        check("restart_reload", rv, 8'h05);
        wr(13'h0C01, 8'h01);   // already enabled: must not restart
        idle(3);
        rd(13'h0C00, rv);
        check("no_restart", rv, 8'h04);

        // ---------------- underflow beats acknowledge ----------------
        wr(13'h0C01, 8'h00);
        wr(13'h1403, 8'h00);
        wr(13'h0C00, 8'h01);
        wr(13'h0C01, 8'h01);
        idle(7);
        wr(13'h1403, 8'hFF);   // lands on the underflow edge
        rd(13'h1403, rv);
        check("set_beats_clear", rv, 8'h04);
        wr(13'h0C01, 8'h00);
        wr(13'h1403, 8'h00);
        rd(13'h1403, rv);
        check("clear_pend", rv, 8'h00);

        // ---------------- randomized traffic ----------------
        for (int i = 0; i < 2000; i++) begin
            int r;
            r  = int'($urandom_range(0, 4));
            cs = ($urandom_range(0, 9) < 7);
            we = $urandom_range(0, 1) == 1;
            if (r < 2)      addr = {3'b011, 8'($urandom), 2'($urandom)};
            else if (r < 4) addr = {3'b101, 8'($urandom), 2'($urandom)};
            else            addr = 13'($urandom);
            if (addr[12:10] == 3'b011 && addr[1:0] == 2'd0)
                di = 8'($urandom_range(0, 7)) | (($urandom_range(0, 7) == 0) ? 8'h78 : 8'h00);
            else if (addr[12:10] == 3'b011 && addr[1:0] == 2'd1)
                di = {7'($urandom), ($urandom_range(0, 3) != 0)};
            else
                di = 8'($urandom);
            if ($urandom_range(0, 7) == 0) irq1_in = ~irq1_in;
            if ($urandom_range(0, 7) == 0) irq2_in = ~irq2_in;
            cycle();
        end
        set_idle();
        irq1_in = 0; irq2_in = 0;
        idle(3);

        // ---------------- reset while running ----------------
        wr(13'h0C01, 8'h00);
        wr(13'h1402, 8'h00);
        wr(13'h1403, 8'h00);
        wr(13'h0C00, 8'h01);
        wr(13'h0C01, 8'h01);
        wait_irq(40, lat);
        check("pre_reset_irq", lat, 9);
        rd(13'h0C01, rv);
        check("pre_reset_enable", rv, 8'h01);
        reset = 1;
        model_reset();
        #1;
        check("async_rst_dout",    dout,       8'h00);
        check("async_rst_dvalid",  dout_valid, 1'b0);
        check("async_rst_irq",     irq,        1'b0);
        check("async_rst_irq_src", irq_src,    2'd0);
        idle(2);
        reset = 0;
        saw_irq = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (irq !== 1'b0) saw_irq = 1;
        end
        check("post_reset_no_irq", saw_irq, 1'b0);
        rd(13'h0C01, rv); check("post_reset_enable",  rv, 8'h00);
        rd(13'h0C00, rv); check("post_reset_counter", rv, 8'h00);
        rd(13'h1403, rv); check("post_reset_status",  rv, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/huc_timer_irq.md
Name: huc_timer_irq

Overview:
- Timer plus interrupt controller feeding the IRQ input of the 65C02 core.
- Memory-mapped in the hardware I/O page:
  - Timer at offsets 0x0C00-0x0FFF.
  - Interrupt controller at offsets 0x1400-0x17FF.
- Merges timer underflow with the two external IRQ lines, applies a disable mask, and drives one level IRQ plus a priority-encoded source ID for vector selection.

Parameters:
- PRESCALE, 1024, clk cycles per timer decrement (minimum 2).
- TIMER_BITS, 7, width of the timer counter and reload registers.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- cs  input  1  CPU access targets the hardware I/O page this cycle
- addr  input  13  offset within the I/O page
- we  input  1  1 = write, 0 = read (qualified by cs)
- di  input  8  CPU write data
- dout  output  8  read data, registered
- dout_valid  output  1  dout holds read data this cycle
- irq1_in  input  1  external IRQ1 request, level, active high
- irq2_in  input  1  external IRQ2 request, level, active high
- irq  output  1  to CPU IRQ, level, active high, registered
- irq_src  output  2  highest-priority unmasked source: 2 = timer, 1 = IRQ1, 0 = IRQ2/none

Behaviour:
- Decode:
  - Timer is selected when cs and addr[12:10]==3'b011.
  - Interrupt controller is selected when cs and addr[12:10]==3'b101.
  - Register is chosen by addr[1:0]; unlisted offsets read 0x00 and ignore writes.
- Reset (async): dout=0, dout_valid=0, irq=0, irq_src=0, reload=0, counter=0, enable=0, presc=0, mask=0, tirq_pend=0.
- Timer 0x0C00, write: reload <= di[TIMER_BITS-1:0]. The running counter is unaffected.
- Timer 0x0C00, read: zero-extended counter.
- Timer 0x0C01, write: enable <= di[0].
  - On a 0->1 transition: counter <= reload (the value in effect before any same-cycle write) and presc <= PRESCALE-1.
  - On 1->0: counter and presc freeze.
  - Writing 1 while already enabled does not restart the counter.
- Timer 0x0C01, read: {7'b0, enable}.
- Counting, while enable=1:
  - presc decrements each clk.
  - When presc==0: presc <= PRESCALE-1; if counter==0 then counter <= reload and tirq_pend <= 1, else counter <= counter-1.
  - Underflow period = (reload+1)*PRESCALE cycles.
- IRQ 0x1402, read/write: mask[2:0]. Bit2 = timer, bit1 = IRQ1, bit0 = IRQ2; 1 = disabled. Read returns {5'b0, mask}.
- IRQ 0x1403, read: {5'b0, tirq_pend, irq1_in, irq2_in}. Status is raw, ignoring the mask.
- IRQ 0x1403, write: any data clears tirq_pend.
  - If an underflow occurs in the same cycle, set wins and tirq_pend stays 1.
- Reads:
  - A read access in cycle N gives dout and dout_valid=1 in cycle N+1.
  - dout_valid=0 otherwise; dout holds its last value.
  - Reads have no side effects.
- Interrupt output:
  - act = {tirq_pend, irq1_in, irq2_in} & ~mask.
  - irq <= |act, registered, so it rises one cycle after the cause.
  - irq_src <= 2 if act[2], else 1 if act[1], else 0.
  - External lines are level-sensitive and never latched; deasserting the input drops irq one cycle later.
- Reset mid-count clears everything immediately; counting resumes only after a new 0->1 enable write.

Optional Feature:
- IRQ_SYNC_EN defined:
  - irq1_in and irq2_in pass through two-flop synchronizers (reset 0) before status and act.
  - External IRQ to irq latency becomes 3 cycles.
  - Status at 0x1403 shows the synchronized values.
- IRQ_SYNC_EN undefined: inputs are used directly, with 1-cycle latency.

Test Plan:
- PRESCALE=4: write 0x0C00=0x02, then 0x0C01=0x01 -> tirq_pend and irq rise 12 cycles (+1 register) after the enable write; read 0x1403 returns 0x04; irq_src=2.
- Timer pending with mask 0x1402=0x04 -> irq=0 while 0x1403 still reads 0x04; write 0x1402=0x00 -> irq=1 next cycle; write 0x1403=0xFF -> irq=0 next cycle.
- irq1_in=1 and irq2_in=1 with timer pending, mask=0 -> irq_src=2; mask=0x04 -> irq_src=1; mask=0x06 -> irq_src=0, irq=1; mask=0x07 -> irq=0.
- Enable the timer, write 0x0C01=0x00 mid-count, read 0x0C00 over 20 cycles -> value constant; re-enable -> counter reloads to reload.
- Force an underflow in the same cycle as a 0x1403 write -> tirq_pend remains 1.
- Assert reset while the timer is running with irq=1 -> all outputs and registers 0 immediately; no irq afterwards without reprogramming.
